// File: rtl/sgd_gradient_sched_if.sv
// Handshake and configuration bundle between the gradient sequencer and its
// surroundings (dot-product stage, feature fifo, run control).
interface sgd_gradient_sched_if;
    logic        started;
    logic [31:0] number_of_epochs;
    logic [31:0] number_of_samples;
    logic [31:0] dimension;
    logic [31:0] number_of_bits;
    logic        ax_valid;
    logic        fifo_a_empty;
    logic        fifo_a_rd_en;
    logic [4:0]  bit_index;
    logic [11:0] chunk_index;
    logic        first_bit;
    logic        last_bit;
    logic        ax_ready;
    logic        busy;
    logic        sample_done;
    logic        epoch_done;
    logic        all_done;
    logic        err_overrun;

    modport master (
        output started, number_of_epochs, number_of_samples, dimension,
               number_of_bits, ax_valid, fifo_a_empty,
        input  fifo_a_rd_en, bit_index, chunk_index, first_bit, last_bit,
               ax_ready, busy, sample_done, epoch_done, all_done, err_overrun
    );

    modport slave (
        input  started, number_of_epochs, number_of_samples, dimension,
               number_of_bits, ax_valid, fifo_a_empty,
        output fifo_a_rd_en, bit_index, chunk_index, first_bit, last_bit,
               ax_ready, busy, sample_done, epoch_done, all_done, err_overrun
    );
endinterface

// File: rtl/sgd_gradient_sched.sv
// Stall-aware sequencer for the bit-serial gradient datapath: one fifo_a read
// per (chunk, bit plane) per sample, then a fixed drain before the next sample.
module sgd_gradient_sched #(
    parameter int BIT_WIDTH_OF_BANK = 9,
    parameter int DRAIN_LATENCY     = 10
) (
    input logic               clk,
    input logic               rst,
    sgd_gradient_sched_if.slave bus
);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT_AX, ISSUE, DRAIN, DONE} state_t;

    state_t      state, state_next;
    logic [11:0] chunk_last;
    logic [4:0]  bit_last;
    logic [31:0] n_samples;
    logic [31:0] n_epochs;
    logic [4:0]  bit_index;
    logic [11:0] chunk_index;
    logic [7:0]  drain_cnt;
    logic [31:0] sample_cnt;
    logic [31:0] epoch_cnt;
    logic        err_overrun;

    // Configuration decode, only consumed while in LOAD.
    logic [31:0] chunks_full;
    logic [11:0] chunks;
    logic [5:0]  nb_raw;
    logic [4:0]  nb_last_in;
    logic        cfg_empty;
    logic        unused_cfg;

    assign chunks_full = (bus.dimension >> BIT_WIDTH_OF_BANK)
                       + {31'd0, |bus.dimension[BIT_WIDTH_OF_BANK-1:0]};
    assign chunks      = chunks_full[11:0];
    assign nb_raw      = bus.number_of_bits[5:0];
    assign nb_last_in  = (nb_raw == 6'd0 || nb_raw > 6'd32) ? 5'd31 : 5'(nb_raw - 6'd1);
    assign cfg_empty   = (chunks == 12'd0) || (bus.number_of_samples == 32'd0)
                       || (bus.number_of_epochs == 32'd0);
    assign unused_cfg  = ^{chunks_full[31:12], bus.number_of_bits[31:6]};

    logic rd_en, last_read, drain_end, sample_last, epoch_last;
    logic ax_ready, busy;

    always_comb begin
        state_next  = state;
        rd_en       = (state == ISSUE) && !bus.fifo_a_empty;
        last_read   = rd_en && (chunk_index == chunk_last) && (bit_index == bit_last);
        drain_end   = (state == DRAIN) && (drain_cnt == 8'd0) && bus.started;
        sample_last = (sample_cnt + 32'd1) == n_samples;
        epoch_last  = (epoch_cnt + 32'd1) == n_epochs;
        ax_ready    = (state == WAIT_AX);
        busy        = (state != IDLE) && (state != DONE);
        case (state)
            IDLE:    if (bus.started) state_next = LOAD;
            LOAD:    if (!bus.started) state_next = IDLE;
                     else if (cfg_empty) state_next = DONE;
                     else state_next = WAIT_AX;
            WAIT_AX: if (!bus.started) state_next = IDLE;
                     else if (bus.ax_valid) state_next = ISSUE;
            ISSUE:   if (!bus.started) state_next = IDLE;
                     else if (last_read) state_next = DRAIN;
            DRAIN:   if (!bus.started) state_next = IDLE;
                     else if (drain_cnt == 8'd0)
                         state_next = (sample_last && epoch_last) ? DONE : WAIT_AX;
            DONE:    if (!bus.started) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            chunk_last  <= '0;
            bit_last    <= '0;
            n_samples   <= '0;
            n_epochs    <= '0;
            bit_index   <= '0;
            chunk_index <= '0;
            drain_cnt   <= '0;
            sample_cnt  <= '0;
            epoch_cnt   <= '0;
            err_overrun <= 1'b0;
        end else begin
            state <= state_next;
            if (bus.ax_valid && busy && !ax_ready)
                err_overrun <= 1'b1;
            case (state)
                IDLE: begin
                    bit_index   <= '0;
                    chunk_index <= '0;
                    drain_cnt   <= '0;
                    sample_cnt  <= '0;
                    epoch_cnt   <= '0;
                end
                LOAD: begin
                    chunk_last <= chunks - 12'd1;
                    bit_last   <= nb_last_in;
                    n_samples  <= bus.number_of_samples;
                    n_epochs   <= bus.number_of_epochs;
                end
                WAIT_AX: begin
                    bit_index   <= '0;
                    chunk_index <= '0;
                end
                ISSUE: if (rd_en) begin
                    if (bit_index == bit_last) begin
                        bit_index   <= '0;
                        chunk_index <= chunk_index + 12'd1;
                    end else begin
                        bit_index <= bit_index + 5'd1;
                    end
                    if (last_read)
                        drain_cnt <= 8'(DRAIN_LATENCY - 1);
                end
                DRAIN: begin
                    if (drain_cnt != 8'd0) begin
                        drain_cnt <= drain_cnt - 8'd1;
                    end else if (bus.started) begin
                        if (sample_last) begin
                            sample_cnt <= '0;
                            epoch_cnt  <= epoch_cnt + 32'd1;
                        end else begin
                            sample_cnt <= sample_cnt + 32'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Index and qualifier outputs are only meaningful alongside a read strobe.
    assign bus.fifo_a_rd_en = rd_en;
    assign bus.bit_index    = bit_index;
    assign bus.chunk_index  = chunk_index;
    assign bus.first_bit    = rd_en && (bit_index == 5'd0);
    assign bus.last_bit     = rd_en && (bit_index == bit_last);
    assign bus.ax_ready     = ax_ready;
    assign bus.busy         = busy;
    assign bus.sample_done  = drain_end;
    assign bus.epoch_done   = drain_end && sample_last;
    assign bus.all_done     = (state == DONE);
    assign bus.err_overrun  = err_overrun;

endmodule

// File: tb/tb_sgd_gradient_sched.sv
// Scoreboard bench for sgd_gradient_sched: stimulus pushes expected reads and
// sample completions into a queue, a negedge monitor pops and compares them.
module tb_sgd_gradient_sched;
    localparam int DL = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sgd_gradient_sched_if bus();

    sgd_gradient_sched #(.BIT_WIDTH_OF_BANK(9), .DRAIN_LATENCY(DL)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        bit is_done;
        int chunk;
        int bitp;
        bit first;
        bit last;
        bit epoch;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad = 0;
    int  reads = 0;
    int  cyc = 0;
    int  last_rd_cyc = 0;
    logic force_empty = 1'b0;
    logic stall_en = 1'b0;
    logic tog = 1'b0;

    assign bus.fifo_a_empty = force_empty | (stall_en & tog);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        tog <= ~tog;
    end

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic miss(string name);
        total++;
        bad++;
        $display("FAIL %s: got an event, expected none", name);
    endtask

    // Monitor
    always @(negedge clk) begin
        ev_t e;
        if (!rst) begin
            if (bus.fifo_a_rd_en) begin
                reads++;
                last_rd_cyc = cyc;
                chk("rd_en_while_empty", int'(bus.fifo_a_empty), 0);
                if (exp_q.size() == 0) miss("unexpected_read");
                else begin
                    e = exp_q.pop_front();
                    chk("read_slot", int'(e.is_done), 0);
                    chk("chunk_index", int'(bus.chunk_index), e.chunk);
                    chk("bit_index", int'(bus.bit_index), e.bitp);
                    chk("first_bit", int'(bus.first_bit), int'(e.first));
                    chk("last_bit", int'(bus.last_bit), int'(e.last));
                end
            end
            if (bus.sample_done) begin
                if (exp_q.size() == 0) miss("unexpected_sample_done");
                else begin
                    e = exp_q.pop_front();
                    chk("sample_slot", int'(e.is_done), 1);
                    chk("epoch_done", int'(bus.epoch_done), int'(e.epoch));
                    chk("drain_latency", cyc - last_rd_cyc, DL);
                end
            end else if (bus.epoch_done) begin
                miss("epoch_done_alone");
            end
        end
    end

    function automatic int chunks_of(int dim);
        return (dim >> 9) + (((dim % 512) != 0) ? 1 : 0);
    endfunction

    function automatic int nb_of(int nbits);
        int v = nbits & 63;
        return (v == 0 || v > 32) ? 32 : v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_read(int ch, int b, int nb);
        ev_t e;
        e.is_done = 0; e.chunk = ch; e.bitp = b;
        e.first = (b == 0); e.last = (b == nb - 1); e.epoch = 0;
        exp_q.push_back(e);
    endtask

    task automatic push_sample(int c, int nb, bit ep);
        ev_t e;
        for (int ch = 0; ch < c; ch++)
            for (int b = 0; b < nb; b++)
                push_read(ch, b, nb);
        e.is_done = 1; e.chunk = 0; e.bitp = 0; e.first = 0; e.last = 0; e.epoch = ep;
        exp_q.push_back(e);
    endtask

    task automatic set_cfg(int dim, int nbits, int ns, int ne);
        bus.dimension         = dim;
        bus.number_of_bits    = nbits;
        bus.number_of_samples = ns;
        bus.number_of_epochs  = ne;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.ax_ready && n < 500) begin step(); n++; end
        chk("ax_ready_reached", int'(bus.ax_ready), 1);
    endtask

    task automatic wait_all_done();
        int n = 0;
        while (!bus.all_done && n < 2000) begin step(); n++; end
        chk("all_done_reached", int'(bus.all_done), 1);
    endtask

    task automatic wait_reads(int base, int target);
        int n = 0;
        while ((reads - base) < target && n < 500) begin step(); n++; end
        chk("reads_reached", reads - base, target);
    endtask

    task automatic pulse_ax();
        bus.ax_valid = 1'b1;
        step();
        bus.ax_valid = 1'b0;
    endtask

    task automatic run(int dim, int nbits, int ns, int ne);
        int base = reads;
        int c = chunks_of(dim);
        int nb = nb_of(nbits);
        set_cfg(dim, nbits, ns, ne);
        bus.started = 1'b1;
        for (int e = 0; e < ne; e++)
            for (int s = 0; s < ns; s++) begin
                push_sample(c, nb, s == ns - 1);
                wait_ready();
                repeat (3) step();
                pulse_ax();
            end
        wait_all_done();
        chk("run_reads", reads - base, c * nb * ns * ne);
        chk("queue_drained", exp_q.size(), 0);
        bus.started = 1'b0;
        step();
        chk("all_done_cleared", int'(bus.all_done), 0);
        step();
    endtask

    initial begin
        int base;
        int dims[3] = '{1024, 0, 1024};
        int nss[3]  = '{1, 1, 0};
        int nes[3]  = '{0, 1, 1};
        bus.started  = 1'b0;
        bus.ax_valid = 1'b0;
        set_cfg(0, 0, 0, 0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_en", int'(bus.fifo_a_rd_en), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_ax_ready", int'(bus.ax_ready), 0);
        chk("rst_all_done", int'(bus.all_done), 0);
        chk("rst_err_overrun", int'(bus.err_overrun), 0);
        chk("rst_sample_done", int'(bus.sample_done), 0);
        chk("rst_first_bit", int'(bus.first_bit), 0);
        chk("rst_chunk_index", int'(bus.chunk_index), 0);
        rst = 1'b0;
        step();

        run(1024, 4, 2, 1);
        run(1024, 4, 1, 2);
        run(513, 0, 1, 1);

        stall_en = 1'b1;
        run(1024, 4, 1, 1);
        stall_en = 1'b0;

        // Overrun: ax_valid while draining
        base = reads;
        set_cfg(1024, 4, 1, 1);
        bus.started = 1'b1;
        push_sample(2, 4, 1'b1);
        wait_ready();
        pulse_ax();
        wait_reads(base, 8);
        step();
        step();
        chk("drain_busy", int'(bus.busy), 1);
        chk("drain_err_before", int'(bus.err_overrun), 0);
        pulse_ax();
        chk("err_overrun_set", int'(bus.err_overrun), 1);
        wait_all_done();
        chk("err_overrun_held", int'(bus.err_overrun), 1);
        chk("overrun_reads", reads - base, 8);
        chk("overrun_queue", exp_q.size(), 0);
        bus.started = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_rst_err", int'(bus.err_overrun), 0);
        chk("async_rst_all_done", int'(bus.all_done), 0);
        step();
        rst = 1'b0;
        step();

        // Abort after five reads, then a fresh run
        base = reads;
        set_cfg(1024, 4, 1, 1);
        bus.started = 1'b1;
        for (int i = 0; i < 5; i++) push_read(i / 4, i % 4, 4);
        wait_ready();
        pulse_ax();
        wait_reads(base, 5);
        force_empty = 1'b1;
        bus.started = 1'b0;
        step();
        chk("abort_idle_busy", int'(bus.busy), 0);
        force_empty = 1'b0;
        repeat (15) step();
        chk("abort_reads", reads - base, 5);
        chk("abort_queue", exp_q.size(), 0);
        run(1024, 4, 1, 1);

        // Degenerate configurations go straight to DONE
        for (int k = 0; k < 3; k++) begin
            base = reads;
            set_cfg(dims[k], 4, nss[k], nes[k]);
            bus.started = 1'b1;
            step();
            chk("degen_load_all_done", int'(bus.all_done), 0);
            chk("degen_load_busy", int'(bus.busy), 1);
            step();
            chk("degen_all_done", int'(bus.all_done), 1);
            repeat (3) step();
            chk("degen_reads", reads - base, 0);
            bus.started = 1'b0;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end
endmodule
